mult_bank_arbiter: RTL and testbench

MULT_BANK_ARBITER -- requirements
Module: mult_bank_arbiter

---
 rtl/mult_sched_pkg.sv | 19 +
 rtl/mult_bank_arbiter_if.sv | 27 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/mult_bank_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mult_bank_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
// Shared encodings for the multiplier-bank scheduler: unit selects, FSM states
// and the default WAIT abort limit.
package mult_sched_pkg;

    localparam logic [1:0] SEL_DSP   = 2'b00;
    localparam logic [1:0] SEL_BOOTH = 2'b01;
    localparam logic [1:0] SEL_BIT   = 2'b10;
    localparam logic [1:0] SEL_SKIP  = 2'b11;

    localparam int unsigned DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

endpackage

// File: rtl/mult_bank_arbiter_if.sv
// Request/response bus between the two requesters and the multiplier-bank
// arbiter; lane i occupies slice i of each packed field.
interface mult_bank_arbiter_if #(
    parameter int unsigned W = 8
);

    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_A;
    logic [2*W-1:0] req_B;
    logic [3:0]     req_sel;
    logic           rsp_valid;
    logic           rsp_id;
    logic [2*W-1:0] rsp_P;
    logic           rsp_err;

    modport master (
        output req_valid, req_A, req_B, req_sel,
        input  req_ready, rsp_valid, rsp_id, rsp_P, rsp_err
    );

    modport slave (
        input  req_valid, req_A, req_B, req_sel,
        output req_ready, rsp_valid, rsp_id, rsp_P, rsp_err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the lane
// not granted last. The history register resets toward lane 1 so lane 0 wins first.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant_q;

    always_comb begin
        grant = 2'b00;
        unique case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else if (advance && (|grant)) begin
            last_grant_q <= grant[1];
        end
    end

endmodule

// File: rtl/mult_bank_arbiter.sv
// Schedules two requesters onto a bank of multiplier units through one shared
// operand bus, with a WAIT timeout and unit-switch / timeout counters.
module mult_bank_arbiter
    import mult_sched_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 reset,
    mult_bank_arbiter_if.slave   bus,
    output logic                 start_dsp,
    output logic                 start_booth,
    output logic                 start_bit,
    input  logic                 done_dsp,
    input  logic                 done_booth,
    input  logic                 done_bit,
    input  logic [2*W-1:0]       P_dsp,
    input  logic [2*W-1:0]       P_booth,
    input  logic [2*W-1:0]       P_bit,
    output logic [W-1:0]         mult_operand_A,
    output logic [W-1:0]         mult_operand_B,
    output logic [31:0]          switch_count,
    output logic [31:0]          timeout_count
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e         state_q, state_d;
    logic [W-1:0]   op_a_q, op_b_q;
    logic [1:0]     sel_q;
    logic           id_q;
    logic [2*W-1:0] p_q;
    logic           err_q;
    logic [CW-1:0]  wait_q;
    logic [1:0]     prev_q;
    logic           prev_v_q;
    logic [31:0]    switch_q, timeout_q;

    logic [1:0]     grant;
    logic           accept;
    logic           gid;
    logic [1:0]     lane_sel;
    logic [W-1:0]   lane_a, lane_b;
    logic           unit_done;
    logic [2*W-1:0] unit_p;
    logic           timeout_hit;

    assign accept   = (state_q == StIdle) && (|bus.req_valid);
    assign gid      = grant[1];
    assign lane_sel = gid ? bus.req_sel[3:2]   : bus.req_sel[1:0];
    assign lane_a   = gid ? bus.req_A[2*W-1:W] : bus.req_A[W-1:0];
    assign lane_b   = gid ? bus.req_B[2*W-1:W] : bus.req_B[W-1:0];

    assign timeout_hit    = (wait_q == CW'(TIMEOUT - 1));
    assign mult_operand_A = op_a_q;
    assign mult_operand_B = op_b_q;
    assign switch_count   = switch_q;
    assign timeout_count  = timeout_q;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  (bus.req_valid),
        .advance(accept),
        .grant  (grant)
    );

    // Only the selected unit's done/product is observed; the others are ignored.
    always_comb begin
        unit_done = 1'b0;
        unit_p    = '0;
        case (sel_q)
            SEL_DSP:   begin unit_done = done_dsp;   unit_p = P_dsp;   end
            SEL_BOOTH: begin unit_done = done_booth; unit_p = P_booth; end
            SEL_BIT:   begin unit_done = done_bit;   unit_p = P_bit;   end
            default:   ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        bus.req_ready = 2'b00;
        start_dsp     = 1'b0;
        start_booth   = 1'b0;
        start_bit     = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_id    = 1'b0;
        bus.rsp_P     = '0;
        bus.rsp_err   = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.req_ready = grant;
                if (accept) state_d = (lane_sel == SEL_SKIP) ? StResp : StIssue;
            end
            StIssue: begin
                start_dsp   = (sel_q == SEL_DSP);
                start_booth = (sel_q == SEL_BOOTH);
                start_bit   = (sel_q == SEL_BIT);
                state_d     = StWait;
            end
            StWait: begin
                if (unit_done || timeout_hit) state_d = StResp;
            end
            StResp: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_id    = id_q;
                bus.rsp_P     = p_q;
                bus.rsp_err   = err_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sel_q     <= SEL_DSP;
            id_q      <= 1'b0;
            p_q       <= '0;
            err_q     <= 1'b0;
            wait_q    <= '0;
            prev_q    <= SEL_DSP;
            prev_v_q  <= 1'b0;
            switch_q  <= '0;
            timeout_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        sel_q  <= lane_sel;
                        id_q   <= gid;
                        p_q    <= '0;
                        err_q  <= 1'b0;
                        wait_q <= '0;
                        // Zero-skip never reaches the units, so the bus keeps its last value.
                        if (lane_sel != SEL_SKIP) begin
                            op_a_q <= lane_a;
                            op_b_q <= lane_b;
                        end
                    end
                end
                StIssue: begin
                    if (prev_v_q && (prev_q != sel_q)) switch_q <= switch_q + 32'd1;
                    prev_q   <= sel_q;
                    prev_v_q <= 1'b1;
                end
                StWait: begin
                    if (unit_done) begin
                        p_q <= unit_p;
                    end else if (timeout_hit) begin
                        err_q     <= 1'b1;
                        timeout_q <= timeout_q + 32'd1;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_bank_arbiter.sv
// Bench for mult_bank_arbiter: behavioural unit models, a transaction-level
// scoreboard, directed vector table, corner sequences and random traffic.
module tb_mult_bank_arbiter;
    import mult_sched_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 20;

    typedef struct {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        logic [1:0]          sel;
    } txn_t;

    typedef struct {
        int         id;
        longint     p;
        int         err;
        int         lat;
        logic [1:0] sel;
    } exp_t;

    typedef struct {
        int         lane;
        int         a;
        int         b;
        logic [1:0] sel;
        longint     p;
        int         err;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start_dsp, start_booth, start_bit;
    logic           done_dsp = 1'b0, done_booth = 1'b0, done_bit = 1'b0;
    logic [2*W-1:0] P_dsp = '0, P_booth = '0, P_bit = '0;
    logic [W-1:0]   mult_operand_A, mult_operand_B;
    logic [31:0]    switch_count, timeout_count;

    mult_bank_arbiter_if #(.W(W)) bus ();

    mult_bank_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .start_dsp     (start_dsp),
        .start_booth   (start_booth),
        .start_bit     (start_bit),
        .done_dsp      (done_dsp),
        .done_booth    (done_booth),
        .done_bit      (done_bit),
        .P_dsp         (P_dsp),
        .P_booth       (P_booth),
        .P_bit         (P_bit),
        .mult_operand_A(mult_operand_A),
        .mult_operand_B(mult_operand_B),
        .switch_count  (switch_count),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;

    int             n_cmp = 0;
    int             n_bad = 0;
    txn_t           q0[$];
    txn_t           q1[$];
    exp_t           cur;
    bit             busy = 1'b0;
    int             age = 0;
    int             m_last = 1;
    bit             m_prev_v = 1'b0;
    logic [1:0]     m_prev = 2'b00;
    longint         exp_sw = 0;
    longint         exp_to = 0;
    int             lat_u[3] = '{3, 4, 5};
    bit             alive[3] = '{1'b1, 1'b1, 1'b1};
    bit             inj[3] = '{1'b0, 1'b0, 1'b0};
    int             ucnt[3] = '{0, 0, 0};
    logic [2*W-1:0] prod[3];
    int             last_id;
    longint         last_p;
    int             last_err;
    int             rsp_ids[$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int lane, input int a, input int b, input logic [1:0] sel);
        txn_t t;
        t.a   = a[W-1:0];
        t.b   = b[W-1:0];
        t.sel = sel;
        if (lane == 0) q0.push_back(t);
        else q1.push_back(t);
    endtask

    // Transaction-level expectation for an accepted request.
    task automatic accept(input int id);
        txn_t t;
        int   u;
        t = (id == 1) ? q1.pop_front() : q0.pop_front();
        m_last  = id;
        cur.id  = id;
        cur.sel = t.sel;
        cur.err = 0;
        if (t.sel == SEL_SKIP) begin
            cur.p   = 0;
            cur.lat = 1;
        end else begin
            u = int'(t.sel);
            if (m_prev_v && m_prev != t.sel) exp_sw++;
            m_prev   = t.sel;
            m_prev_v = 1'b1;
            if (alive[u] && lat_u[u] <= int'(TO)) begin
                cur.p   = longint'(t.a) * longint'(t.b);
                cur.lat = lat_u[u] + 2;
            end else begin
                cur.p   = 0;
                cur.err = 1;
                cur.lat = int'(TO) + 2;
                exp_to++;
            end
        end
        busy = 1'b1;
        age  = 0;
    endtask

    task automatic step();
        logic [1:0]            v;
        logic [1:0]            exp_rdy;
        logic [2:0]            st;
        logic [2:0]            exp_st;
        logic [2:0]            dn;
        logic signed [2*W-1:0] xa, xb;
        int                    r;
        bit                    was_busy;
        @(negedge clk);
        st     = {start_bit, start_booth, start_dsp};
        exp_st = 3'b000;
        if (busy && age == 1 && cur.sel != SEL_SKIP) exp_st = 3'b001 << cur.sel;
        chk("start", st, exp_st);

        // Unit models: start loads a latency countdown, done pulses when it expires.
        xa = $signed(mult_operand_A);
        xb = $signed(mult_operand_B);
        dn = 3'b000;
        for (int u = 0; u < 3; u++) begin
            if (st[u]) begin
                ucnt[u] = lat_u[u];
                prod[u] = xa * xb;
                for (int o = 0; o < 3; o++) begin
                    if (o != u) begin
                        r       = int'($urandom);
                        prod[o] = r[2*W-1:0];
                    end
                end
            end else if (ucnt[u] > 0) begin
                ucnt[u]--;
                if (ucnt[u] == 0 && alive[u]) dn[u] = 1'b1;
            end
        end
        done_dsp   = dn[0] | inj[0];
        done_booth = dn[1] | inj[1];
        done_bit   = dn[2] | inj[2];
        inj        = '{1'b0, 1'b0, 1'b0};
        P_dsp      = prod[0];
        P_booth    = prod[1];
        P_bit      = prod[2];

        v = {q1.size() > 0, q0.size() > 0};
        bus.req_valid = v;
        if (v[0]) begin
            bus.req_A[W-1:0] = q0[0].a;
            bus.req_B[W-1:0] = q0[0].b;
            bus.req_sel[1:0] = q0[0].sel;
        end
        if (v[1]) begin
            bus.req_A[2*W-1:W] = q1[0].a;
            bus.req_B[2*W-1:W] = q1[0].b;
            bus.req_sel[3:2]   = q1[0].sel;
        end
        #1;
        was_busy = busy;
        chk("rsp_valid", bus.rsp_valid, busy && age == cur.lat);
        if (busy && age >= cur.lat) begin
            if (bus.rsp_valid) begin
                chk("rsp_id", bus.rsp_id, cur.id);
                chk("rsp_P", longint'($signed(bus.rsp_P)), cur.p);
                chk("rsp_err", bus.rsp_err, cur.err);
                chk("switch_count", switch_count, exp_sw);
                chk("timeout_count", timeout_count, exp_to);
                last_id  = cur.id;
                last_p   = longint'($signed(bus.rsp_P));
                last_err = int'(bus.rsp_err);
                rsp_ids.push_back(int'(bus.rsp_id));
            end
            busy = 1'b0;
        end
        exp_rdy = was_busy ? 2'b00 : ((v == 2'b11) ? ((m_last == 1) ? 2'b01 : 2'b10) : v);
        chk("req_ready", bus.req_ready, exp_rdy);
        if (exp_rdy != 2'b00) accept(int'(exp_rdy[1]));
        @(posedge clk);
        if (busy) age++;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((busy || q0.size() > 0 || q1.size() > 0) && n < max) begin
            step();
            n++;
        end
        if (busy || q0.size() > 0 || q1.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: still busy after %0d cycles, required idle", n);
            q0.delete();
            q1.delete();
            busy = 1'b0;
        end
        step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        q0.delete();
        q1.delete();
        busy          = 1'b0;
        m_last        = 1;
        m_prev_v      = 1'b0;
        exp_sw        = 0;
        exp_to        = 0;
        bus.req_valid = 2'b00;
        repeat (2) step();
        #2 reset = 1'b0;
        chk("rst_switch_count", switch_count, 0);
        chk("rst_timeout_count", timeout_count, 0);
        chk("rst_operand_A", mult_operand_A, 0);
        chk("rst_operand_B", mult_operand_B, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   n;
        tbl[0] = '{0, 7, 3, SEL_DSP, 21, 0};
        tbl[1] = '{1, 0, 5, SEL_SKIP, 0, 0};
        tbl[2] = '{0, -6, 4, SEL_BOOTH, -24, 0};
        tbl[3] = '{1, 127, -128, SEL_BIT, -16256, 0};
        tbl[4] = '{0, -128, -128, SEL_DSP, 16384, 0};
        tbl[5] = '{1, 5, 5, SEL_SKIP, 0, 0};
        for (int u = 0; u < 3; u++) prod[u] = '0;
        bus.req_valid = 2'b00;
        bus.req_A     = '0;
        bus.req_B     = '0;
        bus.req_sel   = '0;

        do_reset();

        for (int i = 0; i < 6; i++) begin
            last_p   = -999;
            last_err = -1;
            last_id  = -1;
            push(tbl[i].lane, tbl[i].a, tbl[i].b, tbl[i].sel);
            drain(200);
            chk($sformatf("vec%0d_P", i), last_p, tbl[i].p);
            chk($sformatf("vec%0d_err", i), last_err, tbl[i].err);
            chk($sformatf("vec%0d_id", i), last_id, tbl[i].lane);
            if (i == 0) chk("vec0_switch", switch_count, 0);
        end
        chk("table_switch", switch_count, 3);

        // Contention: both lanes stay valid, responses must alternate.
        do_reset();
        lat_u[1] = 2;
        lat_u[2] = 3;
        for (int k = 0; k < 4; k++) begin
            push(0, 7, 8, SEL_BOOTH);
            push(1, 9, 2, SEL_BIT);
        end
        rsp_ids.delete();
        drain(400);
        chk("contend_count", rsp_ids.size(), 8);
        for (int k = 0; k < rsp_ids.size(); k++) chk($sformatf("contend_id%0d", k), rsp_ids[k], k % 2);
        chk("contend_switch", switch_count, 7);

        // Timeout with bit-serial unit silent, then a normal request.
        alive[2] = 1'b0;
        last_p   = -999;
        push(0, 3, 4, SEL_BIT);
        drain(int'(TO) + 20);
        chk("timeout_P", last_p, 0);
        chk("timeout_err", last_err, 1);
        chk("timeout_count", timeout_count, 1);
        alive[2] = 1'b1;
        push(1, 3, 4, SEL_BIT);
        drain(50);
        chk("after_timeout_P", last_p, 12);
        chk("after_timeout_err", last_err, 0);

        // Spurious dones: booth done in ISSUE, dsp/bit done during the Booth WAIT.
        lat_u[1] = 5;
        last_p   = -999;
        push(0, -6, 4, SEL_BOOTH);
        n = 0;
        while ((busy || q0.size() > 0) && n < 50) begin
            if (busy && age == 1) inj[1] = 1'b1;
            if (busy && age == 2) inj[2] = 1'b1;
            if (busy && age == 3) inj[0] = 1'b1;
            step();
            n++;
        end
        drain(20);
        chk("spurious_P", last_p, -24);
        chk("spurious_err", last_err, 0);

        // Random traffic against the scoreboard.
        for (int ph = 0; ph < 4; ph++) begin
            for (int u = 0; u < 3; u++) lat_u[u] = int'($urandom_range(1, 6));
            for (int c = 0; c < 80; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 1) == 0) begin
                        if (q0.size() < 3)
                            push(0, int'($urandom_range(0, 255)) - 128,
                                 int'($urandom_range(0, 255)) - 128, 2'($urandom_range(0, 3)));
                    end else begin
                        if (q1.size() < 3)
                            push(1, int'($urandom_range(0, 255)) - 128,
                                 int'($urandom_range(0, 255)) - 128, 2'($urandom_range(0, 3)));
                    end
                end
                step();
            end
            drain(500);
        end

        // Reset in the middle of a long WAIT; the late done must not produce a response.
        lat_u[2] = 10;
        push(0, 5, 5, SEL_BIT);
        n = 0;
        while (!(busy && age == 4) && n < 20) begin
            step();
            n++;
        end
        chk("reset_wait_reached", busy && age == 4, 1);
        do_reset();
        repeat (15) step();
        push(1, 2, 3, SEL_DSP);
        push(0, 4, 5, SEL_DSP);
        rsp_ids.delete();
        drain(50);
        chk("post_reset_count", rsp_ids.size(), 2);
        if (rsp_ids.size() > 0) chk("post_reset_first_id", rsp_ids[0], 0);
        chk("post_reset_switch", switch_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
